// File: rtl/seq_divider8.sv
// Sequential unsigned restoring divider: one quotient bit per RUN cycle,
// MSB first, IDLE -> RUN -> DONE with a one-cycle done pulse.
//
// Optional feature macro: DIV_ZERO_DETECT_EN
//   When defined, a zero divisor skips RUN and flags div_by_zero.
//   When undefined, div_by_zero is tied low.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - request, sampled only in IDLE
//   dividend        - numerator, captured when start is accepted
//   divisor         - denominator, captured when start is accepted
//   busy            - high while in RUN
//   done            - one-cycle pulse, results valid
//   quotient        - registered quotient
//   remainder       - registered remainder
//   div_by_zero     - registered flag for the last completed division

module seq_divider8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
`ifdef DIV_ZERO_DETECT_EN
    logic             dbz_q, dbz_d;
`endif

    // One restoring step. quo_q starts as the dividend; its MSB is shifted
    // into the partial remainder while the new quotient bit enters at LSB.
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             take;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;

    always_comb begin
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        take    = ~diff[WIDTH+1];
        rem_nx  = take ? diff[WIDTH:0] : shifted;
        quo_nx  = {quo_q[WIDTH-2:0], take};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
        dbz_d       = dbz_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d   = divisor;
                    quo_d   = dividend;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef DIV_ZERO_DETECT_EN
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    quotient_d  = quo_nx;
                    remainder_d = rem_nx[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
                    dbz_d       = 1'b0;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q       <= dbz_d;
`endif
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: doc/seq_divider8.md
SEQ_DIVIDER8 -- requirements
Module: seq_divider8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  WIDTH  numerator; captured when start is accepted.
REQ-006 SHALL have port divisor  input  WIDTH  denominator; captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high while a division is in progress (RUN state).
REQ-008 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port quotient  output  WIDTH  registered quotient.
REQ-010 SHALL have port remainder  output  WIDTH  registered remainder.
REQ-011 SHALL have port div_by_zero  output  1  registered flag for the last completed division.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-013 SHALL accept start only in IDLE; start in RUN or DONE is ignored with no effect on operands or results.
REQ-014 SHALL capture dividend/divisor on the accepting edge; later input changes do not affect the operation in flight.
REQ-015 SHALL perform unsigned restoring division, one quotient bit per RUN cycle, MSB first, using a WIDTH+1-bit partial remainder.
REQ-016 SHALL assert done exactly WIDTH+1 cycles after the start-sampling edge (normal path), for exactly one cycle.
REQ-017 SHALL assert busy for exactly WIDTH cycles per normal division, deasserted in IDLE and DONE.
REQ-018 SHALL update quotient/remainder/div_by_zero only on the edge entering DONE and hold them until the next completion.
REQ-019 SHALL guarantee quotient*divisor + remainder == dividend and remainder < divisor for every divisor != 0.
REQ-020 SHALL accept a new start on the cycle immediately after done (back-to-back throughput one result per WIDTH+2 cycles).

Reset
REQ-021 SHALL, on rst high at a clock edge, enter IDLE and clear busy, done, quotient, remainder, div_by_zero and all internal registers to 0.
REQ-022 SHALL give rst priority over start and over any in-progress operation; an aborted division produces no done pulse.
REQ-023 SHALL ignore start on any edge where rst is high.

Configuration
REQ-024 SHALL honour macro DIV_ZERO_DETECT_EN.
REQ-025 SHALL, with DIV_ZERO_DETECT_EN defined, on accepting start with divisor==0 skip RUN, go directly to DONE (done 1 cycle after the start edge, busy never high), output quotient all-ones, remainder=dividend, div_by_zero=1.
REQ-026 SHALL, with DIV_ZERO_DETECT_EN defined, set div_by_zero=0 for every nonzero-divisor completion.
REQ-027 SHALL, without DIV_ZERO_DETECT_EN, treat divisor==0 as a normal WIDTH-cycle division (natural result quotient all-ones, remainder=dividend) and tie div_by_zero to 0.

Verification
REQ-028 SHALL cover: rst, then start with 200/7 -> done 9 cycles after the start edge, quotient=28, remainder=4, busy high 8 cycles.
REQ-029 SHALL cover: 255/1 then immediately 5/9 back-to-back -> results 255 r0, then 0 r5, second done 10 cycles after the first.
REQ-030 SHALL cover: start 100/3, pulse start with 50/5 during RUN -> second request ignored, result 33 r1, exactly one done.
REQ-031 SHALL cover: start 180/11, assert rst at RUN cycle 4 -> all outputs 0 next cycle, no done; fresh 180/11 afterwards gives 16 r4.
REQ-032 SHALL cover: 77/0 -> with DIV_ZERO_DETECT_EN: done 1 cycle after start, quotient=255, remainder=77, div_by_zero=1; without: done after 9 cycles, same quotient/remainder, div_by_zero=0.
REQ-033 SHALL cover: exhaustive or random 8-bit operand pairs checked against the REQ-019 identity.
